// File: rtl/power_gate_sequencer_if.sv
// rtl/power_gate_sequencer_if.sv - power manager <-> bank sequencer handshake and bank controls
// Optional retention signals appear only when PGS_RETENTION_EN is defined.
interface power_gate_sequencer_if #(
    parameter int NBANK = 4
);
    logic             pwr_req;
    logic             pwr_ack;
    logic [NBANK-1:0] sleep_en;
    logic             iso_en;
    logic             busy;
`ifdef PGS_RETENTION_EN
    logic             save;
    logic             restore;

    modport master (output pwr_req, input pwr_ack, input sleep_en, input iso_en, input busy,
                    input save, input restore);
    modport slave  (input pwr_req, output pwr_ack, output sleep_en, output iso_en, output busy,
                    output save, output restore);
`else
    modport master (output pwr_req, input pwr_ack, input sleep_en, input iso_en, input busy);
    modport slave  (input pwr_req, output pwr_ack, output sleep_en, output iso_en, output busy);
`endif
endinterface

// File: rtl/power_gate_sequencer.sv
// rtl/power_gate_sequencer.sv - staggered sleep-switch sequencer with output isolation bracketing
// Define PGS_RETENTION_EN to add the retention save/restore pulses.
module power_gate_sequencer #(
    parameter int NBANK    = 4,
    parameter int STEP_DLY = 8,
    parameter int ISO_DLY  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    power_gate_sequencer_if.slave  pgs
);
    localparam int MAXD = (STEP_DLY > ISO_DLY) ? STEP_DLY : ISO_DLY;
    localparam int CW   = $clog2(MAXD + 1);
    localparam int IW   = (NBANK > 1) ? $clog2(NBANK) : 1;

    typedef enum logic [2:0] {
        ST_ON  = 3'd0,
        ST_ISO = 3'd1,
        ST_PDN = 3'd2,
        ST_OFF = 3'd3,
        ST_PUP = 3'd4,
        ST_REL = 3'd5
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic [NBANK-1:0] r_sleep_en;
    logic             r_iso_en;
    logic             r_pwr_ack;
    logic             r_busy;

    assign pgs.sleep_en = r_sleep_en;
    assign pgs.iso_en   = r_iso_en;
    assign pgs.pwr_ack  = r_pwr_ack;
    assign pgs.busy     = r_busy;

`ifdef PGS_RETENTION_EN
    logic r_save;
    logic r_restore;
    assign pgs.save    = r_save;
    assign pgs.restore = r_restore;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ON;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_sleep_en <= '0;
            r_iso_en   <= 1'b0;
            r_pwr_ack  <= 1'b1;
            r_busy     <= 1'b0;
`ifdef PGS_RETENTION_EN
            r_save     <= 1'b0;
            r_restore  <= 1'b0;
`endif
        end else begin
`ifdef PGS_RETENTION_EN
            r_save    <= 1'b0;
            r_restore <= 1'b0;
`endif
            case (r_state)
                ST_ON: begin
                    if (!pgs.pwr_req) begin
                        r_state  <= ST_ISO;
                        r_iso_en <= 1'b1;
                        r_busy   <= 1'b1;
                        r_cnt    <= CW'(ISO_DLY - 1);
                    end
                end
                ST_ISO: begin
`ifdef PGS_RETENTION_EN
                    // Clamps have been up for one full cycle before state is saved
                    if (r_cnt == CW'(ISO_DLY - 1)) r_save <= 1'b1;
`endif
                    if (r_cnt == '0) begin
                        r_state       <= ST_PDN;
                        r_sleep_en[0] <= 1'b1;
                        r_idx         <= IW'(1);
                        r_cnt         <= CW'(STEP_DLY - 1);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_PDN: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (&r_sleep_en) begin
                        // Last bank gets a full settle interval before ack drops
                        r_state   <= ST_OFF;
                        r_pwr_ack <= 1'b0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_sleep_en[r_idx] <= 1'b1;
                        r_idx             <= r_idx + 1'b1;
                        r_cnt             <= CW'(STEP_DLY - 1);
                    end
                end
                ST_OFF: begin
                    if (pgs.pwr_req) begin
                        r_busy                <= 1'b1;
                        r_sleep_en[NBANK-1]   <= 1'b0;
                        if (NBANK == 1) begin
                            r_state <= ST_REL;
                            r_cnt   <= CW'(ISO_DLY - 1);
                        end else begin
                            r_state <= ST_PUP;
                            r_idx   <= IW'(NBANK - 2);
                            r_cnt   <= CW'(STEP_DLY - 1);
                        end
                    end
                end
                ST_PUP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_sleep_en[r_idx] <= 1'b0;
                        if (r_idx == '0) begin
                            r_state <= ST_REL;
                            r_cnt   <= CW'(ISO_DLY - 1);
                        end else begin
                            r_idx <= r_idx - 1'b1;
                            r_cnt <= CW'(STEP_DLY - 1);
                        end
                    end
                end
                ST_REL: begin
`ifdef PGS_RETENTION_EN
                    if (r_cnt == CW'(1)) r_restore <= 1'b1;
`endif
                    if (r_cnt == '0) begin
                        r_state   <= ST_ON;
                        r_iso_en  <= 1'b0;
                        r_pwr_ack <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_ON;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_power_gate_sequencer.sv
// tb/tb_power_gate_sequencer.sv - directed-vector bench for power_gate_sequencer
module tb_power_gate_sequencer;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;
    int   cyc;

    power_gate_sequencer_if #(.NBANK(4)) pgs_if_i ();

    power_gate_sequencer #(
        .NBANK    (4),
        .STEP_DLY (8),
        .ISO_DLY  (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pgs   (pgs_if_i.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [3:0] dn_sleep(input int c);
        return {c >= 27, c >= 19, c >= 11, c >= 3};
    endfunction

    function automatic logic [3:0] up_sleep(input int c);
        return {c < 1, c < 9, c < 17, c < 25};
    endfunction

    initial begin
        n_checks = 0;
        n_fails  = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        pgs_if_i.pwr_req = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;

        // Idle in ON with request high
        for (int c = 0; c < 50; c++) begin
            tick();
            check("idle_sleep", 32'(pgs_if_i.sleep_en), 32'h0);
            check("idle_iso",   32'(pgs_if_i.iso_en),   32'h0);
            check("idle_ack",   32'(pgs_if_i.pwr_ack),  32'h1);
            check("idle_busy",  32'(pgs_if_i.busy),     32'h0);
        end

        // Power-down: request dropped at cycle 0
        pgs_if_i.pwr_req = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            tick();
            check("dn_sleep", 32'(pgs_if_i.sleep_en), 32'(dn_sleep(c)));
            check("dn_iso",   32'(pgs_if_i.iso_en),   32'h1);
            check("dn_ack",   32'(pgs_if_i.pwr_ack),  32'(c < 35));
            check("dn_busy",  32'(pgs_if_i.busy),     32'(c <= 34));
`ifdef PGS_RETENTION_EN
            check("dn_save",    32'(pgs_if_i.save),    32'(c == 2));
            check("dn_restore", 32'(pgs_if_i.restore), 32'h0);
`endif
        end

        // Power-up from OFF: request raised at cycle 0
        pgs_if_i.pwr_req = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            check("up_sleep", 32'(pgs_if_i.sleep_en), 32'(up_sleep(c)));
            check("up_iso",   32'(pgs_if_i.iso_en),   32'(c < 27));
            check("up_ack",   32'(pgs_if_i.pwr_ack),  32'(c >= 27));
            check("up_busy",  32'(pgs_if_i.busy),     32'(c <= 26));
`ifdef PGS_RETENTION_EN
            check("up_save",    32'(pgs_if_i.save),    32'h0);
            check("up_restore", 32'(pgs_if_i.restore), 32'(c == 26));
`endif
        end

        // Request toggled back at cycle 5: down completes, then up starts from OFF
        pgs_if_i.pwr_req = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            tick();
            if (c == 5) pgs_if_i.pwr_req = 1'b1;
            check("tg_sleep", 32'(pgs_if_i.sleep_en),
                  32'((c <= 35) ? dn_sleep(c) : up_sleep(c - 35)));
            check("tg_ack",  32'(pgs_if_i.pwr_ack), 32'((c < 35) || (c >= 62)));
            check("tg_busy", 32'(pgs_if_i.busy),    32'((c <= 34) || (c >= 36 && c <= 61)));
        end

        // Asynchronous reset mid power-down with two banks off
        pgs_if_i.pwr_req = 1'b0;
        for (int c = 1; c <= 12; c++) tick();
        check("pre_rst_sleep", 32'(pgs_if_i.sleep_en), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_sleep", 32'(pgs_if_i.sleep_en), 32'h0);
        check("rst_iso",   32'(pgs_if_i.iso_en),   32'h0);
        check("rst_ack",   32'(pgs_if_i.pwr_ack),  32'h1);
        check("rst_busy",  32'(pgs_if_i.busy),     32'h0);
`ifdef PGS_RETENTION_EN
        check("rst_save",    32'(pgs_if_i.save),    32'h0);
        check("rst_restore", 32'(pgs_if_i.restore), 32'h0);
`endif
        pgs_if_i.pwr_req = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check("post_rst_ack",   32'(pgs_if_i.pwr_ack),  32'h1);
            check("post_rst_sleep", 32'(pgs_if_i.sleep_en), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
